red_pitaya_acq_ch: RTL and testbench

//  Single-channel ADC acquisition (scope) channel: the receive-side counterpart of the ASG channel.

---
 rtl/red_pitaya_acq_pkg.sv | 37 +++
 rtl/red_pitaya_acq_trig.sv | 56 +++++
 rtl/red_pitaya_acq_ch.sv | 166 ++++++++++++++++
 tb/tb_red_pitaya_acq_ch.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_acq_pkg.sv
// Shared types and constants for the scope acquisition channel.
// Holds the FSM state encoding, trigger source codes and threshold saturation.
package red_pitaya_acq_pkg;

   localparam int unsigned ADC_W = 14;
   localparam int unsigned DEC_W = 17;
   localparam int unsigned DLY_W = 32;

   localparam logic signed [ADC_W+1:0] ADC_MAX = (ADC_W+2)'(8191);
   localparam logic signed [ADC_W+1:0] ADC_MIN = -(ADC_W+2)'(8192);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMED     = 2'd1,
      TRIGGERED = 2'd2,
      DONE      = 2'd3
   } acq_state_e;

   typedef enum logic [2:0] {
      TRG_NONE = 3'd0,
      TRG_SW   = 3'd1,
      TRG_RISE = 3'd2,
      TRG_FALL = 3'd3,
      TRG_EXT  = 3'd4
   } trig_src_e;

   // Clamp a widened threshold back into the signed ADC range.
   function automatic logic signed [ADC_W-1:0] sat_adc(input logic signed [ADC_W+1:0] x);
      if (x > ADC_MAX)
         return ADC_W'(ADC_MAX);
      else if (x < ADC_MIN)
         return ADC_W'(ADC_MIN);
      else
         return ADC_W'(x);
   endfunction

endpackage

// File: rtl/red_pitaya_acq_trig.sv
// Level trigger with hysteresis: a rearm flag must be set by crossing the far
// threshold before a crossing of the level itself produces an event.
module red_pitaya_acq_trig
   import red_pitaya_acq_pkg::*;
(
   input  logic                    adc_clk_i,
   input  logic                    adc_rst_i,
   input  logic                    arm_clr,
   input  logic                    smp_vld,
   input  logic signed [ADC_W-1:0] sample,
   input  logic signed [ADC_W-1:0] lvl,
   input  logic        [ADC_W-1:0] hyst,
   output logic                    rise_p,
   output logic                    fall_p
);

   logic signed [ADC_W+1:0] lvl_x;
   logic signed [ADC_W+1:0] hyst_x;
   logic signed [ADC_W-1:0] lo;
   logic signed [ADC_W-1:0] hi;
   logic                    rise_arm;
   logic                    fall_arm;
   logic                    rise_hit;
   logic                    fall_hit;

   assign lvl_x  = {{2{lvl[ADC_W-1]}}, lvl};
   assign hyst_x = {2'b00, hyst};
   assign lo     = sat_adc(lvl_x - hyst_x);
   assign hi     = sat_adc(lvl_x + hyst_x);

   assign rise_hit = rise_arm && (sample >= lvl);
   assign fall_hit = fall_arm && (sample <= lvl);
   assign rise_p   = smp_vld && rise_hit;
   assign fall_p   = smp_vld && fall_hit;

   // Rearm flags; cleared on entry to ARMED so a stale level cannot fire.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         rise_arm <= 1'b0;
         fall_arm <= 1'b0;
      end else if (arm_clr) begin
         rise_arm <= 1'b0;
         fall_arm <= 1'b0;
      end else if (smp_vld) begin
         if (rise_hit)
            rise_arm <= 1'b0;
         else if (sample < lo)
            rise_arm <= 1'b1;
         if (fall_hit)
            fall_arm <= 1'b0;
         else if (sample > hi)
            fall_arm <= 1'b1;
      end
   end

endmodule

// File: rtl/red_pitaya_acq_ch.sv
// Single-channel scope acquisition: decimator, circular capture buffer,
// trigger selection and the IDLE/ARMED/TRIGGERED/DONE capture sequencer.
module red_pitaya_acq_ch
   import red_pitaya_acq_pkg::*;
#(
   parameter int unsigned RSZ = 14
)(
   input  logic                    adc_clk_i,
   input  logic                    adc_rst_i,
   input  logic signed [ADC_W-1:0] adc_dat_i,
   input  logic        [DEC_W-1:0] set_dec_i,
   input  logic signed [ADC_W-1:0] set_lvl_i,
   input  logic        [ADC_W-1:0] set_hyst_i,
   input  logic        [DLY_W-1:0] set_dly_i,
   input  logic        [2:0]       trig_src_i,
   input  logic                    trig_sw_i,
   input  logic                    trig_ext_i,
   input  logic                    arm_i,
   input  logic                    set_rst_i,
   input  logic        [RSZ-1:0]   buf_addr_i,
   output logic        [ADC_W-1:0] buf_rdata_o,
   output logic        [RSZ-1:0]   wr_ptr_o,
   output logic        [RSZ-1:0]   trg_ptr_o,
   output logic                    armed_o,
   output logic                    trig_o,
   output logic                    done_o
);

   localparam int unsigned DEPTH = 2**RSZ;

   acq_state_e              state;
   acq_state_e              state_nxt;
   logic [DEC_W-1:0]        dec_cnt;
   logic [DEC_W-1:0]        dec_last;
   logic                    smp_vld;
   logic signed [ADC_W-1:0] smp_dat;
   logic [RSZ-1:0]          wr_ptr_nxt;
   logic [DLY_W-1:0]        dly_cnt;
   logic                    wr_en_c;
   logic                    trg_ld_c;
   logic                    arm_clr_c;
   logic                    trig_evt_c;
   logic                    rise_p;
   logic                    fall_p;
   logic [ADC_W-1:0]        mem [DEPTH];

   // N of 0 or 1 both collapse to a sample every cycle.
   assign dec_last = (set_dec_i > DEC_W'(1)) ? set_dec_i - DEC_W'(1) : '0;

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         dec_cnt <= '0;
         smp_vld <= 1'b0;
         smp_dat <= '0;
      end else if (arm_i || set_rst_i) begin
         dec_cnt <= '0;
         smp_vld <= 1'b0;
      end else begin
         smp_vld <= (dec_cnt >= dec_last);
         if (dec_cnt >= dec_last) begin
            dec_cnt <= '0;
            smp_dat <= adc_dat_i;
         end else begin
            dec_cnt <= dec_cnt + DEC_W'(1);
         end
      end
   end

   red_pitaya_acq_trig u_trig (
      .adc_clk_i (adc_clk_i),
      .adc_rst_i (adc_rst_i),
      .arm_clr   (arm_clr_c),
      .smp_vld   (smp_vld),
      .sample    (smp_dat),
      .lvl       (set_lvl_i),
      .hyst      (set_hyst_i),
      .rise_p    (rise_p),
      .fall_p    (fall_p)
   );

   always_comb begin
      trig_evt_c = 1'b0;
      case (trig_src_e'(trig_src_i))
         TRG_SW:   trig_evt_c = trig_sw_i;
         TRG_RISE: trig_evt_c = rise_p;
         TRG_FALL: trig_evt_c = fall_p;
         TRG_EXT:  trig_evt_c = trig_ext_i;
         default:  trig_evt_c = 1'b0;
      endcase
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Software reset overrides arm and trigger requests in the same cycle.
   always_comb begin
      state_nxt = state;
      trg_ld_c  = 1'b0;
      wr_en_c   = smp_vld && !set_rst_i && ((state == ARMED) || (state == TRIGGERED));
      case (state)
         IDLE:      if (arm_i) state_nxt = ARMED;
         ARMED: begin
            if (trig_evt_c) begin
               state_nxt = TRIGGERED;
               trg_ld_c  = 1'b1;
            end
         end
         TRIGGERED: if (wr_en_c && (dly_cnt == '0)) state_nxt = DONE;
         DONE:      if (arm_i) state_nxt = ARMED;
         default:   state_nxt = IDLE;
      endcase
      if (set_rst_i) begin
         state_nxt = IDLE;
         trg_ld_c  = 1'b0;
      end
   end

   assign arm_clr_c  = (state_nxt == ARMED) && (state != ARMED);
   assign wr_ptr_nxt = wr_ptr_o + RSZ'(wr_en_c);

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         wr_ptr_o  <= '0;
         trg_ptr_o <= '0;
         dly_cnt   <= '0;
         trig_o    <= 1'b0;
         armed_o   <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         trig_o  <= trg_ld_c;
         armed_o <= (state_nxt == ARMED);
         done_o  <= (state_nxt == DONE);
         if (set_rst_i) begin
            wr_ptr_o  <= '0;
            trg_ptr_o <= '0;
            dly_cnt   <= '0;
         end else begin
            wr_ptr_o <= wr_ptr_nxt;
            if (trg_ld_c) begin
               trg_ptr_o <= wr_ptr_nxt;
               dly_cnt   <= set_dly_i;
            end else if ((state == TRIGGERED) && wr_en_c && (dly_cnt != '0)) begin
               dly_cnt <= dly_cnt - DLY_W'(1);
            end
         end
      end
   end

   // Capture buffer: one write port, registered read port (read-before-write).
   always_ff @(posedge adc_clk_i) begin
      if (wr_en_c)
         mem[wr_ptr_o] <= smp_dat;
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i)
         buf_rdata_o <= '0;
      else
         buf_rdata_o <= mem[buf_addr_i];
   end

endmodule

// File: tb/tb_red_pitaya_acq_ch.sv
// Scenario bench for red_pitaya_acq_ch with a read-back scoreboard;
// the buffer is instantiated 16 deep so wrap-around is cheap to reach.
module tb_red_pitaya_acq_ch;

   localparam int unsigned RSZ = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [13:0] adc_dat_i = '0;
   logic [16:0]        set_dec_i = '0;
   logic signed [13:0] set_lvl_i = '0;
   logic [13:0]        set_hyst_i = '0;
   logic [31:0]        set_dly_i = '0;
   logic [2:0]         trig_src_i = '0;
   logic               trig_sw_i = 1'b0;
   logic               trig_ext_i = 1'b0;
   logic               arm_i = 1'b0;
   logic               set_rst_i = 1'b0;
   logic [RSZ-1:0]     buf_addr_i = '0;
   logic [13:0]        buf_rdata_o;
   logic [RSZ-1:0]     wr_ptr_o;
   logic [RSZ-1:0]     trg_ptr_o;
   logic               armed_o;
   logic               trig_o;
   logic               done_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [RSZ-1:0] addr;
      logic [13:0]    data;
   } rd_t;
   rd_t  sb_q[$];
   logic rd_req = 1'b0;
   logic rd_vld = 1'b0;

   always #5 clk = ~clk;

   red_pitaya_acq_ch #(.RSZ(RSZ)) dut (
      .adc_clk_i   (clk),
      .adc_rst_i   (rst),
      .adc_dat_i   (adc_dat_i),
      .set_dec_i   (set_dec_i),
      .set_lvl_i   (set_lvl_i),
      .set_hyst_i  (set_hyst_i),
      .set_dly_i   (set_dly_i),
      .trig_src_i  (trig_src_i),
      .trig_sw_i   (trig_sw_i),
      .trig_ext_i  (trig_ext_i),
      .arm_i       (arm_i),
      .set_rst_i   (set_rst_i),
      .buf_addr_i  (buf_addr_i),
      .buf_rdata_o (buf_rdata_o),
      .wr_ptr_o    (wr_ptr_o),
      .trg_ptr_o   (trg_ptr_o),
      .armed_o     (armed_o),
      .trig_o      (trig_o),
      .done_o      (done_o)
   );

   // Read data returns one clock after the address; pop and compare then.
   always @(posedge clk) rd_vld <= rd_req;

   always @(negedge clk) begin
      if (rd_vld) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow got data %0d with no expected entry", buf_rdata_o);
         end else begin
            rd_t e;
            e = sb_q.pop_front();
            if (buf_rdata_o !== e.data) begin
               failures++;
               $display("FAIL buf_rd addr=%0d got %0d exp %0d", e.addr, buf_rdata_o, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_push(input int addr, input int exp);
      rd_t e;
      e.addr = RSZ'(addr);
      e.data = 14'(exp);
      sb_q.push_back(e);
      buf_addr_i = RSZ'(addr);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic rd_drain();
      repeat (2) tick();
   endtask

   task automatic soft_rst();
      set_rst_i = 1'b1;
      tick();
      set_rst_i = 1'b0;
   endtask

   task automatic arm();
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({wr_ptr_o, trg_ptr_o, armed_o, trig_o, done_o, buf_rdata_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got wr=%0d trg=%0d arm=%0b trig=%0b done=%0b rd=%0d exp all 0",
                  wr_ptr_o, trg_ptr_o, armed_o, trig_o, done_o, buf_rdata_o);
      end
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (armed_o !== 1'b0 || wr_ptr_o !== '0) begin
         failures++;
         $display("FAIL reset_idle got arm=%0b wr=%0d exp 0 0", armed_o, wr_ptr_o);
      end
   endtask

   task automatic test_sw_trigger();
      int exp_wp;
      set_dec_i = 17'd1; trig_src_i = 3'd1; set_dly_i = 32'd3;
      soft_rst(); arm();
      for (int j = 1; j <= 20; j++) begin
         adc_dat_i = 14'(j - 1);
         trig_sw_i = (j == 11);
         tick();
         trig_sw_i = 1'b0;
         exp_wp = (j - 1 > 14) ? 14 : j - 1;
         checks++;
         if (wr_ptr_o !== RSZ'(exp_wp)) begin
            failures++;
            $display("FAIL sw_wr_ptr j=%0d got %0d exp %0d", j, wr_ptr_o, exp_wp);
         end
         checks++;
         if (trig_o !== (j == 11) || done_o !== (j >= 15) || armed_o !== (j <= 10)) begin
            failures++;
            $display("FAIL sw_flags j=%0d got trig=%0b done=%0b arm=%0b exp %0b %0b %0b",
                     j, trig_o, done_o, armed_o, j == 11, j >= 15, j <= 10);
         end
      end
      checks++;
      if (trg_ptr_o !== RSZ'(10)) begin
         failures++;
         $display("FAIL sw_trg_ptr got %0d exp 10", trg_ptr_o);
      end
      for (int a = 8; a <= 13; a++) rd_push(a, a);
      rd_drain();
      arm();
      checks++;
      if (armed_o !== 1'b1 || done_o !== 1'b0 || trg_ptr_o !== RSZ'(10) || wr_ptr_o !== RSZ'(14)) begin
         failures++;
         $display("FAIL rearm got arm=%0b done=%0b trg=%0d wr=%0d exp 1 0 10 14",
                  armed_o, done_o, trg_ptr_o, wr_ptr_o);
      end
   endtask

   task automatic test_level_rise();
      int seq[16] = '{90, 90, 90, 90, 150, 150, 150, 150, 70, 70, 70, 101, 101, 101, 101, 101};
      set_dec_i = 17'd1; trig_src_i = 3'd2; set_lvl_i = 14'(100); set_hyst_i = 14'(20);
      set_dly_i = 32'd0; adc_dat_i = 14'(90);
      soft_rst(); arm();
      for (int j = 1; j <= 17; j++) begin
         adc_dat_i = 14'(seq[(j - 1 > 15) ? 15 : j - 1]);
         tick();
         checks++;
         if (trig_o !== (j == 13) || done_o !== (j >= 14)) begin
            failures++;
            $display("FAIL rise_flags j=%0d got trig=%0b done=%0b exp %0b %0b",
                     j, trig_o, done_o, j == 13, j >= 14);
         end
      end
      checks++;
      if (trg_ptr_o !== RSZ'(12) || wr_ptr_o !== RSZ'(13)) begin
         failures++;
         $display("FAIL rise_ptrs got trg=%0d wr=%0d exp 12 13", trg_ptr_o, wr_ptr_o);
      end
      rd_push(11, 101); rd_push(10, 70); rd_push(12, 101); rd_push(4, 150);
      rd_drain();
   endtask

   task automatic test_level_fall();
      int seq[8] = '{-60, -60, -30, -45, -50, -50, -50, -50};
      set_dec_i = 17'd0; trig_src_i = 3'd3; set_lvl_i = 14'(-50); set_hyst_i = 14'(10);
      set_dly_i = 32'd1; adc_dat_i = 14'(-60);
      soft_rst(); arm();
      for (int j = 1; j <= 10; j++) begin
         adc_dat_i = 14'(seq[(j - 1 > 7) ? 7 : j - 1]);
         tick();
         checks++;
         if (trig_o !== (j == 6) || done_o !== (j >= 8)) begin
            failures++;
            $display("FAIL fall_flags j=%0d got trig=%0b done=%0b exp %0b %0b",
                     j, trig_o, done_o, j == 6, j >= 8);
         end
      end
      checks++;
      if (trg_ptr_o !== RSZ'(5) || wr_ptr_o !== RSZ'(7)) begin
         failures++;
         $display("FAIL fall_ptrs got trg=%0d wr=%0d exp 5 7", trg_ptr_o, wr_ptr_o);
      end
      rd_push(2, -30); rd_push(4, -50);
      rd_drain();
   endtask

   task automatic test_decimation();
      int nw;
      set_dec_i = 17'd4; trig_src_i = 3'd1; set_dly_i = 32'd2;
      soft_rst(); arm();
      for (int j = 1; j <= 32; j++) begin
         adc_dat_i = 14'(j - 1);
         trig_sw_i = (j == 15);
         tick();
         trig_sw_i = 1'b0;
         nw = (j < 5) ? 0 : (j - 5) / 4 + 1;
         if (nw > 6) nw = 6;
         checks++;
         if (wr_ptr_o !== RSZ'(nw) || trig_o !== (j == 15) || done_o !== (j >= 25)) begin
            failures++;
            $display("FAIL dec j=%0d got wr=%0d trig=%0b done=%0b exp %0d %0b %0b",
                     j, wr_ptr_o, trig_o, done_o, nw, j == 15, j >= 25);
         end
      end
      checks++;
      if (trg_ptr_o !== RSZ'(3)) begin
         failures++;
         $display("FAIL dec_trg_ptr got %0d exp 3", trg_ptr_o);
      end
      for (int m = 0; m < 6; m++) rd_push(m, 4 * m + 3);
      rd_drain();
   endtask

   task automatic test_wrap();
      int trig_seen = 0;
      set_dec_i = 17'd1; trig_src_i = 3'd0;
      soft_rst(); arm();
      for (int j = 1; j <= 41; j++) begin
         adc_dat_i = 14'(j - 1);
         trig_sw_i = (j == 20);
         tick();
         trig_sw_i = 1'b0;
         if (trig_o) trig_seen++;
      end
      checks++;
      if (wr_ptr_o !== RSZ'(8) || armed_o !== 1'b1 || trig_seen != 0) begin
         failures++;
         $display("FAIL wrap got wr=%0d arm=%0b trigs=%0d exp 8 1 0", wr_ptr_o, armed_o, trig_seen);
      end
      soft_rst();
      for (int a = 0; a < 8; a++) rd_push(a, 32 + a);
      rd_push(8, 24); rd_push(15, 31);
      rd_drain();
   endtask

   task automatic test_rst_priority();
      set_dec_i = 17'd1; trig_src_i = 3'd1; set_dly_i = 32'd100;
      soft_rst(); arm();
      for (int j = 1; j <= 10; j++) begin
         adc_dat_i = 14'(500 + j - 1);
         trig_sw_i = (j == 6);
         tick();
         trig_sw_i = 1'b0;
      end
      checks++;
      if (trg_ptr_o !== RSZ'(5) || wr_ptr_o !== RSZ'(9)) begin
         failures++;
         $display("FAIL prio_pre got trg=%0d wr=%0d exp 5 9", trg_ptr_o, wr_ptr_o);
      end
      set_rst_i = 1'b1; arm_i = 1'b1; adc_dat_i = 14'(900);
      tick();
      set_rst_i = 1'b0; arm_i = 1'b0;
      checks++;
      if (armed_o !== 1'b0 || done_o !== 1'b0 || wr_ptr_o !== '0 || trg_ptr_o !== '0) begin
         failures++;
         $display("FAIL prio_rst got arm=%0b done=%0b wr=%0d trg=%0d exp 0 0 0 0",
                  armed_o, done_o, wr_ptr_o, trg_ptr_o);
      end
      for (int j = 0; j < 5; j++) begin
         adc_dat_i = 14'(901 + j);
         tick();
         checks++;
         if (wr_ptr_o !== '0 || armed_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle j=%0d got wr=%0d arm=%0b exp 0 0", j, wr_ptr_o, armed_o);
         end
      end
      trig_src_i = 3'd4; trig_ext_i = 1'b1;
      tick();
      trig_ext_i = 1'b0;
      tick();
      checks++;
      if (trig_o !== 1'b0 || armed_o !== 1'b0 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL ext_idle got trig=%0b arm=%0b done=%0b exp 0 0 0", trig_o, armed_o, done_o);
      end
      rd_push(0, 500); rd_push(3, 503);
      rd_drain();
   endtask

   task automatic test_async_reset();
      set_dec_i = 17'd1; trig_src_i = 3'd4; set_dly_i = 32'd100;
      soft_rst(); arm();
      for (int j = 1; j <= 8; j++) begin
         adc_dat_i = 14'(j - 1);
         trig_ext_i = (j == 4);
         tick();
         trig_ext_i = 1'b0;
      end
      checks++;
      if (trg_ptr_o !== RSZ'(3) || wr_ptr_o !== RSZ'(7)) begin
         failures++;
         $display("FAIL arst_pre got trg=%0d wr=%0d exp 3 7", trg_ptr_o, wr_ptr_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({wr_ptr_o, trg_ptr_o, armed_o, trig_o, done_o, buf_rdata_o} !== '0) begin
         failures++;
         $display("FAIL arst_now got wr=%0d trg=%0d arm=%0b trig=%0b done=%0b rd=%0d exp all 0",
                  wr_ptr_o, trg_ptr_o, armed_o, trig_o, done_o, buf_rdata_o);
      end
      repeat (2) tick();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         adc_dat_i = 14'(50 + j);
         tick();
         checks++;
         if (wr_ptr_o !== '0 || armed_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL arst_idle j=%0d got wr=%0d arm=%0b done=%0b exp 0 0 0",
                     j, wr_ptr_o, armed_o, done_o);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sw_trigger();
      test_level_rise();
      test_level_fall();
      test_decimation();
      test_wrap();
      test_rst_priority();
      test_async_reset();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got %0d entries exp 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
